// File: rtl/store_queue_pkg.sv
// Store queue shared types and sizing.
// Entry record, drain states, pointer widths.
package store_queue_pkg;

  localparam int SQ_NUM     = 8;
  localparam int SQ_SEL     = 3;
  localparam int CNT_W      = SQ_SEL + 1;
  localparam int ROB_SEL    = 5;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_SEL-1:0]    rob_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_ok;
    logic                  committed;
  } sq_entry_t;

  typedef enum logic {
    SQ_IDLE,
    SQ_REQ
  } sq_drain_e;

endpackage

// File: rtl/sq_ptr_ring.sv
// Head/commit/tail ring pointers with occupancy.
// In: alloc/commit/drain/flush. Out: pointers, full, empty.
module sq_ptr_ring
  import store_queue_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc,
  input  logic              commit,
  input  logic              drain,
  input  logic              flush,
  output logic [SQ_SEL-1:0] head,
  output logic [SQ_SEL-1:0] cmt,
  output logic [SQ_SEL-1:0] tail,
  output logic              full,
  output logic              empty
);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  // committed but not yet drained
  logic [CNT_W-1:0]  ncmt;
  logic [CNT_W-1:0]  ncmt_n;
  logic [SQ_SEL-1:0] cmt_n;

  always_comb begin
    cmt_n  = cmt + SQ_SEL'(commit);
    ncmt_n = ncmt + CNT_W'(commit)
           - CNT_W'(drain);
    // flush keeps only committed entries
    if (flush)
      count_n = ncmt_n;
    else
      count_n = count + CNT_W'(alloc)
              - CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      cmt   <= '0;
      tail  <= '0;
      count <= '0;
      ncmt  <= '0;
    end else begin
      head  <= head + SQ_SEL'(drain);
      cmt   <= cmt_n;
      tail  <= flush ? cmt_n
                     : tail + SQ_SEL'(alloc);
      count <= count_n;
      ncmt  <= ncmt_n;
    end
  end

  assign full  = count == CNT_W'(SQ_NUM);
  assign empty = count == '0;

endmodule

// File: rtl/store_queue.sv
// In-order store buffer draining committed stores.
// Dispatch/writeback/commit in; mem_req valid/ready out.
module store_queue
  import store_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dispatch_valid,
  input  logic [ROB_SEL-1:0]    dispatch_rob,
  output logic [SQ_SEL-1:0]     dispatch_idx,
  input  logic                  addr_valid,
  input  logic [SQ_SEL-1:0]     addr_idx,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  data_valid,
  input  logic [SQ_SEL-1:0]     data_idx,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  commit_valid,
  output logic                  commit_ready,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_req_ready,
  output logic                  sq_full,
  output logic                  sq_empty
);

  sq_entry_t         q [SQ_NUM];
  sq_entry_t         fresh;
  sq_drain_e         state;
  sq_drain_e         state_n;
  logic [SQ_SEL-1:0] head;
  logic [SQ_SEL-1:0] head_nx;
  logic [SQ_SEL-1:0] cmt;
  logic [SQ_SEL-1:0] tail;
  logic              alloc;
  logic              commit;
  logic              drain;

  sq_ptr_ring u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .alloc   (alloc),
    .commit  (commit),
    .drain   (drain),
    .flush   (flush),
    .head    (head),
    .cmt     (cmt),
    .tail    (tail),
    .full    (sq_full),
    .empty   (sq_empty)
  );

  assign dispatch_idx = tail;
  assign alloc = dispatch_valid && !sq_full
              && !flush;
  assign commit_ready = q[cmt].valid
                     && q[cmt].addr_ok
                     && q[cmt].data_ok
                     && !q[cmt].committed;
  assign commit = commit_valid && commit_ready;

  assign mem_req_valid = state == SQ_REQ;
  assign mem_req_addr  = q[head].addr;
  assign mem_req_data  = q[head].data;
  assign drain = mem_req_valid && mem_req_ready;
  assign head_nx = head + SQ_SEL'(1);

  always_comb begin
    fresh         = '0;
    fresh.valid   = 1'b1;
    fresh.rob_idx = dispatch_rob;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SQ_IDLE:
        if (q[head].committed)
          state_n = SQ_REQ;
      SQ_REQ:
        if (mem_req_ready)
          state_n = q[head_nx].committed
                  ? SQ_REQ : SQ_IDLE;
      default: state_n = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= SQ_IDLE;
    else
      state <= state_n;
  end

  // later assignments take priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SQ_NUM; i++)
        q[i] <= '0;
    end else begin
      for (int i = 0; i < SQ_NUM; i++) begin
        if (addr_valid
            && addr_idx == SQ_SEL'(i)
            && q[i].valid
            && !q[i].committed) begin
          q[i].addr    <= addr_in;
          q[i].addr_ok <= 1'b1;
        end
        if (data_valid
            && data_idx == SQ_SEL'(i)
            && q[i].valid
            && !q[i].committed) begin
          q[i].data    <= data_in;
          q[i].data_ok <= 1'b1;
        end
        if (commit && cmt == SQ_SEL'(i))
          q[i].committed <= 1'b1;
        // a same-cycle commit survives flush
        if (flush && !q[i].committed
            && !(commit && cmt == SQ_SEL'(i)))
          q[i] <= '0;
        if (drain && head == SQ_SEL'(i))
          q[i] <= '0;
        if (alloc && tail == SQ_SEL'(i))
          q[i] <= fresh;
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue.
// Vector table plus fill, collide, reset, flush, wrap.
module tb_store_queue;
  import store_queue_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  dispatch_valid;
  logic [ROB_SEL-1:0]    dispatch_rob;
  logic [SQ_SEL-1:0]     dispatch_idx;
  logic                  addr_valid;
  logic [SQ_SEL-1:0]     addr_idx;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  data_valid;
  logic [SQ_SEL-1:0]     data_idx;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  commit_valid;
  logic                  commit_ready;
  logic                  flush;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic                  mem_req_ready;
  logic                  sq_full;
  logic                  sq_empty;

  int n_chk = 0;
  int n_fail = 0;

  store_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dispatch_valid (dispatch_valid),
    .dispatch_rob   (dispatch_rob),
    .dispatch_idx   (dispatch_idx),
    .addr_valid     (addr_valid),
    .addr_idx       (addr_idx),
    .addr_in        (addr_in),
    .data_valid     (data_valid),
    .data_idx       (data_idx),
    .data_in        (data_in),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ready  (mem_req_ready),
    .sq_full        (sq_full),
    .sq_empty       (sq_empty)
  );

  always #5 clk = ~clk;

  // ctl = {disp, addr_v, data_v, commit_v, ready}
  // ef  = {commit_ready, full, empty, mem_valid}
  typedef struct {
    logic [4:0]  ctl;
    logic [2:0]  ai;
    logic [31:0] a;
    logic [2:0]  di;
    logic [31:0] d;
    logic [2:0]  e_idx;
    logic [3:0]  ef;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    dispatch_rob   = '0;
    addr_valid     = 1'b0;
    addr_idx       = '0;
    addr_in        = '0;
    data_valid     = 1'b0;
    data_idx       = '0;
    data_in        = '0;
    commit_valid   = 1'b0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wb(input logic [2:0] idx,
                    input logic [31:0] a,
                    input logic [31:0] d);
    addr_valid = 1'b1;
    addr_idx   = idx;
    addr_in    = a;
    data_valid = 1'b1;
    data_idx   = idx;
    data_in    = d;
    tick();
    addr_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    int got;
    logic [31:0] ga [2];
    logic [31:0] gd [2];
    int issued;
    int drained;
    int cnt;
    logic pend;
    logic acc;
    logic hs;
    logic [2:0] pidx;
    logic [2:0] cur;
    int pk;

    tbl[0]  = '{5'b10000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0000, 32'h0, 32'h0};
    tbl[1]  = '{5'b01000, 3'd0, 32'h100, 3'd0, 32'h0,
                3'd1, 4'b0000, 32'h0, 32'h0};
    tbl[2]  = '{5'b00100, 3'd0, 32'h0, 3'd0, 32'hAA,
                3'd1, 4'b1000, 32'h0, 32'h0};
    tbl[3]  = '{5'b00010, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0000, 32'h0, 32'h0};
    tbl[4]  = '{5'b00000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0001, 32'h100, 32'hAA};
    tbl[5]  = '{5'b00000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0001, 32'h100, 32'hAA};
    tbl[6]  = '{5'b00000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0001, 32'h100, 32'hAA};
    tbl[7]  = '{5'b00000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0001, 32'h100, 32'hAA};
    tbl[8]  = '{5'b00001, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd1, 4'b0010, 32'h0, 32'h0};
    tbl[9]  = '{5'b11100, 3'd1, 32'h200, 3'd1, 32'hBB,
                3'd2, 4'b0000, 32'h0, 32'h0};
    tbl[10] = '{5'b01100, 3'd1, 32'h200, 3'd1, 32'hBB,
                3'd2, 4'b1000, 32'h0, 32'h0};
    tbl[11] = '{5'b00011, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd2, 4'b0000, 32'h0, 32'h0};
    tbl[12] = '{5'b00001, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd2, 4'b0001, 32'h200, 32'hBB};
    tbl[13] = '{5'b00001, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd2, 4'b0010, 32'h0, 32'h0};
    tbl[14] = '{5'b00010, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd2, 4'b0010, 32'h0, 32'h0};
    tbl[15] = '{5'b01000, 3'd2, 32'h999, 3'd0, 32'h0,
                3'd2, 4'b0010, 32'h0, 32'h0};
    tbl[16] = '{5'b10000, 3'd0, 32'h0, 3'd0, 32'h0,
                3'd3, 4'b0000, 32'h0, 32'h0};
    tbl[17] = '{5'b00100, 3'd0, 32'h0, 3'd2, 32'hCC,
                3'd3, 4'b0000, 32'h0, 32'h0};
    tbl[18] = '{5'b01000, 3'd2, 32'h300, 3'd0, 32'h0,
                3'd3, 4'b1000, 32'h0, 32'h0};

    do_reset();
    chk("rst empty", 32'(sq_empty), 32'd1);
    chk("rst full", 32'(sq_full), 32'd0);
    chk("rst mvalid", 32'(mem_req_valid), 32'd0);
    chk("rst cready", 32'(commit_ready), 32'd0);
    chk("rst idx", 32'(dispatch_idx), 32'd0);

    // table-driven retire sequence
    for (int i = 0; i < 19; i++) begin
      dispatch_valid = tbl[i].ctl[4];
      dispatch_rob   = 5'(i);
      addr_valid     = tbl[i].ctl[3];
      addr_idx       = tbl[i].ai;
      addr_in        = tbl[i].a;
      data_valid     = tbl[i].ctl[2];
      data_idx       = tbl[i].di;
      data_in        = tbl[i].d;
      commit_valid   = tbl[i].ctl[1];
      mem_req_ready  = tbl[i].ctl[0];
      tick();
      chk($sformatf("v%0d idx", i),
          32'(dispatch_idx), 32'(tbl[i].e_idx));
      chk($sformatf("v%0d cready", i),
          32'(commit_ready), 32'(tbl[i].ef[3]));
      chk($sformatf("v%0d full", i),
          32'(sq_full), 32'(tbl[i].ef[2]));
      chk($sformatf("v%0d empty", i),
          32'(sq_empty), 32'(tbl[i].ef[1]));
      chk($sformatf("v%0d mvalid", i),
          32'(mem_req_valid), 32'(tbl[i].ef[0]));
      if (tbl[i].ef[0]) begin
        chk($sformatf("v%0d maddr", i),
            mem_req_addr, tbl[i].e_addr);
        chk($sformatf("v%0d mdata", i),
            mem_req_data, tbl[i].e_data);
      end
    end
    idle();

    // fill to full, ninth dispatch ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill idx%0d", i),
          32'(dispatch_idx), 32'(i));
      dispatch_valid = 1'b1;
      dispatch_rob   = 5'(i);
      tick();
    end
    dispatch_valid = 1'b0;
    chk("fill full", 32'(sq_full), 32'd1);
    chk("fill tail", 32'(dispatch_idx), 32'd0);
    dispatch_valid = 1'b1;
    tick();
    dispatch_valid = 1'b0;
    chk("ninth full", 32'(sq_full), 32'd1);
    chk("ninth tail", 32'(dispatch_idx), 32'd0);

    // dispatch at full while drain handshakes
    wb(3'd0, 32'h500, 32'h55);
    chk("col cready", 32'(commit_ready), 32'd1);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick();
    chk("col mvalid", 32'(mem_req_valid), 32'd1);
    chk("col maddr", mem_req_addr, 32'h500);
    dispatch_valid = 1'b1;
    mem_req_ready  = 1'b1;
    tick();
    dispatch_valid = 1'b0;
    mem_req_ready  = 1'b0;
    chk("col full", 32'(sq_full), 32'd0);
    chk("col tail", 32'(dispatch_idx), 32'd0);
    chk("col mvalid2", 32'(mem_req_valid), 32'd0);
    dispatch_valid = 1'b1;
    tick();
    dispatch_valid = 1'b0;
    chk("refill idx", 32'(dispatch_idx), 32'd1);
    chk("refill full", 32'(sq_full), 32'd1);

    // async reset while a drain is pending
    wb(3'd1, 32'h600, 32'h66);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick();
    chk("mid mvalid", 32'(mem_req_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid rst mvalid", 32'(mem_req_valid), 32'd0);
    chk("mid rst empty", 32'(sq_empty), 32'd1);
    chk("mid rst full", 32'(sq_full), 32'd0);
    chk("mid rst idx", 32'(dispatch_idx), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // flush with same-cycle commit and dispatch
    for (int i = 0; i < 4; i++) begin
      dispatch_valid = 1'b1;
      dispatch_rob   = 5'(i);
      tick();
    end
    dispatch_valid = 1'b0;
    wb(3'd0, 32'h300, 32'h1);
    wb(3'd1, 32'h304, 32'h2);
    wb(3'd2, 32'h308, 32'h3);
    commit_valid = 1'b1;
    tick();
    commit_valid   = 1'b1;
    flush          = 1'b1;
    dispatch_valid = 1'b1;
    tick();
    idle();
    chk("fl tail", 32'(dispatch_idx), 32'd2);
    chk("fl cready", 32'(commit_ready), 32'd0);
    chk("fl empty", 32'(sq_empty), 32'd0);
    chk("fl full", 32'(sq_full), 32'd0);
    got = 0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (mem_req_valid) begin
        if (got < 2) begin
          ga[got] = mem_req_addr;
          gd[got] = mem_req_data;
        end
        got++;
      end
      tick();
    end
    mem_req_ready = 1'b0;
    chk("fl drains", 32'(got), 32'd2);
    chk("fl addr0", ga[0], 32'h300);
    chk("fl data0", gd[0], 32'h1);
    chk("fl addr1", ga[1], 32'h304);
    chk("fl data1", gd[1], 32'h2);
    chk("fl end empty", 32'(sq_empty), 32'd1);

    // 20-store stream across pointer wrap
    do_reset();
    issued  = 0;
    drained = 0;
    cnt     = 0;
    pend    = 1'b0;
    pidx    = '0;
    pk      = 0;
    for (int c = 0; c < 300 && drained < 20; c++) begin
      mem_req_ready  = 1'b1;
      dispatch_valid = issued < 20;
      dispatch_rob   = 5'(issued);
      addr_valid     = pend;
      addr_idx       = pidx;
      addr_in        = 32'h1000 + 32'(pk * 4);
      data_valid     = pend;
      data_idx       = pidx;
      data_in        = 32'hD00 + 32'(pk);
      commit_valid   = commit_ready;
      acc = dispatch_valid && !sq_full;
      hs  = mem_req_valid;
      cur = dispatch_idx;
      if (acc)
        chk($sformatf("wr idx%0d", issued),
            32'(cur), 32'(issued % 8));
      if (hs) begin
        chk($sformatf("wr addr%0d", drained),
            mem_req_addr,
            32'h1000 + 32'(drained * 4));
        chk($sformatf("wr data%0d", drained),
            mem_req_data,
            32'hD00 + 32'(drained));
        drained++;
      end
      tick();
      pend = acc;
      pidx = cur;
      pk   = issued;
      if (acc) issued++;
      cnt = cnt + (acc ? 1 : 0) - (hs ? 1 : 0);
      if (sq_full !== (cnt == 8)
          || sq_empty !== (cnt == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr occ: full %0b empty %0b model count %0d",
                 sq_full, sq_empty, cnt);
      end
    end
    idle();
    chk("wr issued", 32'(issued), 32'd20);
    chk("wr drained", 32'(drained), 32'd20);
    chk("wr end empty", 32'(sq_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
